cci_mpf_shim_wro_filter_arb: RTL

Arbiter that shares the single test/insert port of the WRO hashed address filter between the read request channel (c0) and the write request channel (c1). Each request is tested against in-flight addresses; a conflict-free request is granted and inserted, and a conflicting one is retried. Saturating per-channel stall counters enforce fairness. Sits between the channel request buffers and the filter inside the WRO filter group.

---
 rtl/cci_mpf_shim_wro_arb_pkg.sv | 24 ++
 rtl/cci_mpf_shim_wro_stall_ctr.sv | 39 +++
 rtl/cci_mpf_shim_wro_filter_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cci_mpf_shim_wro_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_shim_wro_arb_pkg
// Brief    : Shared types for the WRO filter test/insert port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cci_mpf_shim_wro_arb_pkg;

    localparam int c_wro_hash_bits = 9;

    typedef logic [c_wro_hash_bits-1:0] t_wro_hash;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOOKUP = 1'b1
    } t_wro_arb_state;

    typedef logic t_wro_chan;

    localparam t_wro_chan c_chan_c0 = 1'b0;
    localparam t_wro_chan c_chan_c1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cci_mpf_shim_wro_stall_ctr.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_shim_wro_stall_ctr
// Brief    : Saturating per-channel conflict retry counter.
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_shim_wro_stall_ctr #(
    parameter int MAX_STALL = 15,
    parameter int CTR_BITS  = $clog2(MAX_STALL + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_max,
    output logic hit_max
);

    localparam logic [CTR_BITS-1:0] c_max    = CTR_BITS'(MAX_STALL);
    localparam logic [CTR_BITS-1:0] c_max_m1 = CTR_BITS'(MAX_STALL - 1);

    logic [CTR_BITS-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign at_max  = (r_count == c_max);
    // Fires only on the increment that lands on the ceiling, not while pinned there
    assign hit_max = inc && !clr && (r_count == c_max_m1);

endmodule
`default_nettype wire

// File: rtl/cci_mpf_shim_wro_filter_arb.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_shim_wro_filter_arb
// Brief    : Shares the WRO filter test/insert port between c0 and c1 requests.
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_shim_wro_filter_arb
    import cci_mpf_shim_wro_arb_pkg::*;
#(
    parameter int ADDRESS_HASH_BITS = 9,
    parameter int MAX_STALL         = 15
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         c0_req_valid,
    input  logic [ADDRESS_HASH_BITS-1:0] c0_req_hash,
    output logic                         c0_grant,

    input  logic                         c1_req_valid,
    input  logic [ADDRESS_HASH_BITS-1:0] c1_req_hash,
    output logic                         c1_grant,

    input  logic                         fiu_almost_full,

    output logic                         filter_test_valid,
    output logic [ADDRESS_HASH_BITS-1:0] filter_test_hash,
    output logic                         filter_test_is_write,
    input  logic                         filter_test_conflict,

    output logic                         filter_insert_en,
    output logic [ADDRESS_HASH_BITS-1:0] filter_insert_hash,
    output logic                         filter_insert_is_write,

    output logic                         evt_conflict,
    output logic                         evt_starve
);

    t_wro_arb_state               r_state;
    t_wro_arb_state               w_state_next;
    t_wro_chan                    r_sel_chan;
    logic [ADDRESS_HASH_BITS-1:0] r_sel_hash;
    t_wro_chan                    r_rr;

    logic                         w_sel_ok;
    t_wro_chan                    w_sel_chan;
    logic [ADDRESS_HASH_BITS-1:0] w_test_hash;
    logic                         w_test;
    logic                         w_lat_valid;
    logic                         w_lookup_live;
    logic                         w_grant;
    logic                         w_conflict;

    logic [1:0]                   w_inc;
    logic [1:0]                   w_clr;
    logic [1:0]                   w_at_max;
    logic [1:0]                   w_hit_max;

    // A starved channel locks out the other one even while its own valid is low
    always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_chan = c_chan_c0;
        if (w_at_max[1]) begin
            w_sel_ok   = c1_req_valid;
            w_sel_chan = c_chan_c1;
        end else if (w_at_max[0]) begin
            w_sel_ok   = c0_req_valid;
            w_sel_chan = c_chan_c0;
        end else if (c0_req_valid && c1_req_valid) begin
            w_sel_ok   = 1'b1;
            w_sel_chan = r_rr;
        end else if (c1_req_valid) begin
            w_sel_ok   = 1'b1;
            w_sel_chan = c_chan_c1;
        end else if (c0_req_valid) begin
            w_sel_ok   = 1'b1;
            w_sel_chan = c_chan_c0;
        end
    end

    assign w_test_hash   = (w_sel_chan == c_chan_c1) ? c1_req_hash : c0_req_hash;
    assign w_test        = reset_n && (r_state == ARB) && !fiu_almost_full && w_sel_ok;

    // A requester that dropped valid mid-lookup gets nothing; the FSM just returns to ARB
    assign w_lat_valid   = (r_sel_chan == c_chan_c1) ? c1_req_valid : c0_req_valid;
    assign w_lookup_live = reset_n && (r_state == LOOKUP) && w_lat_valid;
    assign w_grant       = w_lookup_live && !filter_test_conflict;
    assign w_conflict    = w_lookup_live && filter_test_conflict;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB:     if (w_test) w_state_next = LOOKUP;
            LOOKUP:  w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_chan <= c_chan_c0;
            r_sel_hash <= '0;
            r_rr       <= c_chan_c0;
        end else begin
            if (w_test) begin
                r_sel_chan <= w_sel_chan;
                r_sel_hash <= w_test_hash;
            end
            if (w_grant) begin
                r_rr <= ~r_sel_chan;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_stall
        assign w_inc[i] = w_conflict && (r_sel_chan == 1'(i));
        assign w_clr[i] = w_grant && (r_sel_chan == 1'(i));

        cci_mpf_shim_wro_stall_ctr #(
            .MAX_STALL (MAX_STALL)
        ) u_stall_ctr (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (w_inc[i]),
            .clr     (w_clr[i]),
            .at_max  (w_at_max[i]),
            .hit_max (w_hit_max[i])
        );
    end

    assign c0_grant               = w_grant && (r_sel_chan == c_chan_c0);
    assign c1_grant               = w_grant && (r_sel_chan == c_chan_c1);

    assign filter_test_valid      = w_test;
    assign filter_test_hash       = w_test ? w_test_hash : '0;
    assign filter_test_is_write   = w_test && (w_sel_chan == c_chan_c1);

    assign filter_insert_en       = w_grant;
    assign filter_insert_hash     = w_grant ? r_sel_hash : '0;
    assign filter_insert_is_write = w_grant && (r_sel_chan == c_chan_c1);

    assign evt_conflict           = w_conflict;
    assign evt_starve             = |w_hit_max;

endmodule
`default_nettype wire
